uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the core's data-memory bus, downstream of the core, beside dmem.
- The address decode in the top level routes the dmem bus signals (we, a, wd, rd) to either dmem or this block.
- The core writes bytes into a TX FIFO; a baud-rate FSM serialises them 8N1, LSB first, on a single pin.
- A status register lets firmware poll for full, empty, busy and overflow.

Parameters:
- BASE_ADDR, 32'h0000_1000: byte address of register 0; the block decodes a[31:4] == BASE_ADDR[31:4].
- FIFO_DEPTH, 8: TX FIFO entries; power of two, 2..16.
- CLKS_PER_BIT, 16'd234: reset value of the DIV register, in clk cycles per bit.

Ports:
- clk  in  1: single system clock; all state on posedge.
- rst  in  1: synchronous, active-high reset.
- we  in  1: write strobe from the core data port; qualified by the address decode.
- a  in  32: byte address from the core data port.
- wd  in  32: write data.
- rd  out  32: read data; combinational function of a and current state. Returns 0 when the address does not decode.
- tx  out  1: serial output; idles high.
- busy  out  1: high while a frame is on the line or the FIFO is non-empty.

Behaviour:
- Register map (a[3:2]; a[1:0] ignored):
  - 0 TXDATA: a write pushes wd[7:0]; a read returns 0.
  - 1 STATUS (read): bit0 full, bit1 empty, bit2 shifter active, bit3 overflow (sticky), bits[8:4] FIFO count, all others 0.
  - 1 STATUS (write): writing 1 to bit3 clears overflow; other bits are ignored.
  - 2 DIV: 16-bit read/write, read zero-extended. A write of a value < 2 stores 2.
  - 3: reserved; reads 0, writes ignored.
- Reset: FIFO empty, count=0, overflow=0, DIV=CLKS_PER_BIT, FSM=IDLE, tx=1, busy=0. Reset takes effect mid-frame: tx returns high the next cycle and the partial frame is abandoned.
- Write acceptance: a write decodes when we=1 and the address matches; it is sampled on posedge clk with single-cycle effect. There is no wait state.
- Push when full: count == FIFO_DEPTH is evaluated before any same-cycle pop. The byte is dropped, overflow is set, and FIFO contents are unchanged.
- Simultaneous push and pop (not full): both occur, and count is unchanged.
- FIFO: circular buffer with wrap-around read/write pointers. count has width clog2(FIFO_DEPTH)+1.
- FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, latch DIV into the bit timer, and go to START. The pop happens in the IDLE cycle.
  - START: tx=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for DIV cycles per bit, shifting right after each. After bit 7 completes, go to STOP.
  - STOP: tx=1 for DIV cycles, then go to IDLE.
- Bit timer: down-counter loaded with latched_div-1 on entry to each bit; the bit ends the cycle it reads 0. Each bit therefore lasts exactly latched_div cycles.
- Frame timing:
  - A frame is 10*latched_div cycles.
  - Back-to-back frames add one IDLE cycle between the stop bit and the next start bit.
  - First-byte latency: the write is at edge N; IDLE pops at edge N+1; tx falls after edge N+2.
- A DIV write mid-frame does not affect the current frame; it applies at the next IDLE pop.
- busy = (state != IDLE) | ~empty. STATUS bit2 = (state != IDLE).

Test Plan:
- Reset/defaults: assert rst for 2 cycles → tx=1, busy=0. STATUS read = 32'h0000_0002. DIV read = CLKS_PER_BIT.
- Single byte, DIV=4: write 0x1000=32'hA5 → tx falls 2 cycles later and holds for 4 cycles. Then bits 1,0,1,0,0,1,0,1 (LSB first), 4 cycles each. Then stop high for 4 cycles; busy drops when the FSM returns to IDLE.
- Overflow, FIFO_DEPTH=8, DIV=100:
  - Write bytes 0x00..0x09 on consecutive cycles. The first pops into the shifter, so the FIFO holds 8 and the 10th write is dropped.
  - STATUS shows full=1, overflow=1, count=8.
  - Writing STATUS with 32'h8 → overflow=0.
- Back-to-back: queue 0x55, 0xFF with DIV=2 → two 20-cycle frames separated by exactly one IDLE cycle. The decoded serial stream matches.
- DIV clamp and mid-frame change:
  - Write DIV=0 → reads 2.
  - During a DIV=8 frame, write DIV=3 → the current frame keeps 8-cycle bits and the next frame uses 3-cycle bits.
- Reset mid-frame: assert rst during bit 4 → the next cycle tx=1 and the FIFO is empty. A new write then produces a clean frame.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, status/divider registers and a
// baud-rate serialiser on a single output pin.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [15:0] CLKS_PER_BIT = 16'd234
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [15:0]      div;
    logic [15:0]      latched_div;
    logic [15:0]      timer;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    logic hit, full, empty, active;
    logic wr_data, wr_status, wr_div;
    logic push, pop;
    logic unused;

    assign unused    = ^{wd[31:16], a[1:0]};
    assign hit       = (a[31:4] == BASE_ADDR[31:4]);
    assign wr_data   = we && hit && (a[3:2] == 2'd0);
    assign wr_status = we && hit && (a[3:2] == 2'd1);
    assign wr_div    = we && hit && (a[3:2] == 2'd2);

    assign full   = (count == CNT_W'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign active = (state != IDLE);
    assign busy   = active || !empty;

    // Full is judged before the same-cycle pop, so a push at full is always dropped.
    assign push = wr_data && !full;
    assign pop  = (state == IDLE) && !empty;

    always_comb begin
        rd = '0;
        if (hit) begin
            case (a[3:2])
                2'd1:    rd = {23'b0, 5'(count), overflow, active, empty, full};
                2'd2:    rd = {16'b0, div};
                default: rd = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wd[7:0];
        end
    end

    // FIFO pointers, occupancy and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            div      <= CLKS_PER_BIT;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (wr_data && full) begin
                overflow <= 1'b1;
            end else if (wr_status && wd[3]) begin
                overflow <= 1'b0;
            end
            if (wr_div) begin
                div <= (wd[15:0] < 16'd2) ? 16'd2 : wd[15:0];
            end
        end
    end

    // Serialiser; tx is registered from the current state, so it trails state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tx          <= 1'b1;
            timer       <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            latched_div <= CLKS_PER_BIT;
        end else begin
            case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shift[0];
                default: tx <= 1'b1;
            endcase
            case (state)
                IDLE: begin
                    if (!empty) begin
                        shift       <= mem[rd_ptr];
                        latched_div <= div;
                        timer       <= div - 16'd1;
                        state       <= START;
                    end
                end
                START: begin
                    if (timer == '0) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        timer   <= latched_div - 16'd1;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                DATA: begin
                    if (timer == '0) begin
                        shift <= {1'b0, shift[7:1]};
                        timer <= latched_div - 16'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: begin
                    if (timer == '0) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register map, frame timing, overflow,
// divider clamping, mid-frame divider change and mid-frame reset.
module tb_uart_tx_mmio;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        tx;
    logic        busy;

    int total = 0;
    int bad   = 0;

    uart_tx_mmio dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .a    (a),
        .wd   (wd),
        .rd   (rd),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        we = 1'b1;
        a  = addr;
        wd = data;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        a = addr;
        #1;
        data = rd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Advance on negedges until tx goes low; a timeout counts as a failure.
    task automatic wait_start(input string tag, input int bound);
        bit found = 0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            if (tx == 1'b0) found = 1;
        end
        check({tag, "_start"}, 32'(found), 32'd1);
    endtask

    // Entered on the first negedge of the start bit; returns on the negedge after the stop bit.
    task automatic check_frame(input string tag, input logic [7:0] data, input int div);
        logic exp_bit;
        int   ok;
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      exp_bit = 1'b0;
            else if (b == 9) exp_bit = 1'b1;
            else             exp_bit = data[b-1];
            ok = 0;
            for (int c = 0; c < div; c++) begin
                if (tx === exp_bit) ok++;
                @(negedge clk);
            end
            check($sformatf("%s_bit%0d", tag, b), 32'(ok), 32'(div));
        end
    endtask

    logic [31:0] r;

    initial begin
        rst = 1'b0;
        we  = 1'b0;
        a   = '0;
        wd  = '0;

        // Reset defaults and register map
        do_reset();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        bus_read(32'h1004, r); check("rst_status", r, 32'h0000_0002);
        bus_read(32'h1008, r); check("rst_div", r, 32'd234);
        bus_read(32'h1000, r); check("txdata_read", r, 32'd0);
        bus_read(32'h100C, r); check("reserved_read", r, 32'd0);
        bus_read(32'h2008, r); check("nodecode_read", r, 32'd0);
        bus_write(32'h2000, 32'h77);
        bus_read(32'h1004, r); check("nodecode_write", r, 32'h0000_0002);

        // DIV clamp
        bus_write(32'h1008, 32'd0);
        bus_read(32'h1008, r); check("div_clamp0", r, 32'd2);
        bus_write(32'h1008, 32'd1);
        bus_read(32'h1008, r); check("div_clamp1", r, 32'd2);
        bus_write(32'h1008, 32'hFFFF_0005);
        bus_read(32'h1008, r); check("div_upper", r, 32'd5);

        // Single byte with exact first-byte latency
        bus_write(32'h1008, 32'd4);
        bus_write(32'h1000, 32'hA5);
        @(negedge clk);
        check("lat_n0", 32'(tx), 32'd1);
        check("busy_q", 32'(busy), 32'd1);
        @(negedge clk);
        check("lat_n1", 32'(tx), 32'd1);
        @(negedge clk);
        check("lat_n2", 32'(tx), 32'd0);
        check_frame("a5", 8'hA5, 4);
        check("a5_busy_end", 32'(busy), 32'd0);
        bus_read(32'h1004, r); check("a5_status_end", r, 32'h0000_0002);

        // Back-to-back frames with one idle cycle between them
        bus_write(32'h1008, 32'd2);
        bus_write(32'h1000, 32'h55);
        bus_write(32'h1000, 32'hFF);
        wait_start("b2b", 10);
        check_frame("f55", 8'h55, 2);
        check("b2b_gap", 32'(tx), 32'd1);
        @(negedge clk);
        check_frame("fff", 8'hFF, 2);
        check("b2b_busy_end", 32'(busy), 32'd0);

        // DIV change mid-frame applies only to the next frame
        bus_write(32'h1008, 32'd8);
        bus_write(32'h1000, 32'h3C);
        bus_write(32'h1008, 32'd3);
        bus_write(32'h1000, 32'hC3);
        wait_start("divchg", 10);
        check_frame("f3c", 8'h3C, 8);
        check("divchg_gap", 32'(tx), 32'd1);
        @(negedge clk);
        check_frame("fc3", 8'hC3, 3);

        // Overflow
        bus_write(32'h1008, 32'd100);
        for (int i = 0; i < 10; i++) bus_write(32'h1000, 32'(i));
        bus_read(32'h1004, r); check("ovf_status", r, 32'h0000_008D);
        bus_write(32'h1004, 32'h8);
        bus_read(32'h1004, r); check("ovf_clear", r, 32'h0000_0085);

        // Reset mid-frame during data bit 4
        do_reset();
        bus_write(32'h1008, 32'd4);
        bus_write(32'h1000, 32'hA5);
        bus_write(32'h1000, 32'h11);
        wait_start("midrst", 10);
        repeat (22) @(negedge clk);
        check("midrst_pre_tx", 32'(tx), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus_read(32'h1004, r); check("midrst_status", r, 32'h0000_0002);
        check("midrst_busy", 32'(busy), 32'd0);
        bus_write(32'h1008, 32'd4);
        bus_write(32'h1000, 32'h5A);
        wait_start("post_rst", 10);
        check_frame("f5a", 8'h5A, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
